// File: rtl/record_pkg.sv
// Shared types and constants for the I2S-to-SRAM audio recorder.
package record_pkg;

  localparam int ADDR_W   = 20;
  localparam int SAMPLE_W = 16;
  localparam int CNT_W    = $clog2(SAMPLE_W);
  localparam logic [ADDR_W-1:0] MAX_ADDR = 20'hFFFFF;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_L,
    SHIFT,
    WRITE,
    PAUSED
  } state_e;

endpackage

// File: rtl/i2s_rx_shifter.sv
// Left-channel I2S receiver: LRCK falling-edge detect, 16-bit MSB-first shifter
// and bit counter. The controller decides when a word is armed or abandoned.
module i2s_rx_shifter
  import record_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                lrck_i,
  input  logic                dat_i,
  input  logic                start_i,
  input  logic                abort_i,
  output logic                fall_o,
  output logic                last_o,
  output logic [SAMPLE_W-1:0] sample_o,
  output logic                sample_valid_o
);

  logic                lrck_q, lrck_d;
  logic                active_q, active_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] shift_q, shift_d;
  logic                valid_q, valid_d;

  // lrck_q is the registered copy of the word clock; it resets high so a
  // low LRCK right after reset already counts as a falling edge.
  assign fall_o         = lrck_q & ~lrck_i;
  assign last_o         = active_q & (cnt_q == CNT_W'(SAMPLE_W - 1));
  assign sample_o       = shift_q;
  assign sample_valid_o = valid_q;

  always_comb begin
    lrck_d   = lrck_i;
    active_d = active_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    valid_d  = 1'b0;
    if (abort_i) begin
      active_d = 1'b0;
      cnt_d    = '0;
    end else if (start_i) begin
      active_d = 1'b1;
      cnt_d    = '0;
    end else if (active_q) begin
      shift_d = {shift_q[SAMPLE_W-2:0], dat_i};
      cnt_d   = cnt_q + CNT_W'(1);
      if (last_o) begin
        active_d = 1'b0;
        valid_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lrck_q   <= 1'b1;
      active_q <= 1'b0;
      cnt_q    <= '0;
      shift_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      lrck_q   <= lrck_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: rtl/record_ctrl.sv
// Recording controller: captures left I2S words and stores them to SRAM at
// consecutive addresses, with pause/resume, stop and full-memory auto-finish.
module record_ctrl
  import record_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_pause,
  input  logic                i_stop,
  input  logic                i_ADCLRCK,
  input  logic                i_ADCDAT,
  output logic [ADDR_W-1:0]   o_sram_addr,
  output logic [SAMPLE_W-1:0] o_sram_dq,
  output logic                o_sram_we,
  output logic                o_sram_ce,
  output logic                o_sram_oe,
  output logic                o_sram_lb,
  output logic                o_sram_ub,
  output logic [ADDR_W-1:0]   o_end_addr,
  output logic                o_finish,
  output state_e              o_dbg_state
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   end_q, end_d;
  logic                pause_q, pause_d;
  logic                finish_q, finish_d;
  logic                ctl_q;
  logic                fall, last, sample_valid;
  logic                shift_start, shift_abort, write_en;
  logic [SAMPLE_W-1:0] sample;

  i2s_rx_shifter u_shifter (
    .clk_i          (i_clk),
    .rst_i          (i_rst),
    .lrck_i         (i_ADCLRCK),
    .dat_i          (i_ADCDAT),
    .start_i        (shift_start),
    .abort_i        (shift_abort),
    .fall_o         (fall),
    .last_o         (last),
    .sample_o       (sample),
    .sample_valid_o (sample_valid)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    end_d       = end_q;
    pause_d     = pause_q;
    finish_d    = 1'b0;
    shift_start = 1'b0;
    shift_abort = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = WAIT_L;
          addr_d  = '0;
          end_d   = '0;
          pause_d = 1'b0;
        end
      end
      WAIT_L: begin
        if (i_stop) begin
          state_d  = IDLE;
          finish_d = 1'b1;
          end_d    = addr_q;
        end else begin
          if (i_pause) pause_d = 1'b1;
          if (fall) begin
            state_d     = SHIFT;
            shift_start = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (i_stop) begin
          state_d     = IDLE;
          finish_d    = 1'b1;
          end_d       = addr_q;
          shift_abort = 1'b1;
        end else begin
          if (i_pause) pause_d = 1'b1;
          if (last) state_d = WRITE;
        end
      end
      WRITE: begin
        // The last SRAM word ends the take without wrapping the address.
        if (addr_q == MAX_ADDR) begin
          state_d  = IDLE;
          finish_d = 1'b1;
          end_d    = MAX_ADDR;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          if (i_stop) begin
            state_d  = IDLE;
            finish_d = 1'b1;
            end_d    = addr_q + ADDR_W'(1);
          end else if (pause_q || i_pause) begin
            state_d = PAUSED;
          end else begin
            state_d = WAIT_L;
            pause_d = 1'b0;
          end
        end
      end
      PAUSED: begin
        if (i_stop) begin
          state_d  = IDLE;
          finish_d = 1'b1;
          end_d    = addr_q;
        end else if (i_start) begin
          state_d = WAIT_L;
          pause_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      end_q    <= '0;
      pause_q  <= 1'b0;
      finish_q <= 1'b0;
      ctl_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      end_q    <= end_d;
      pause_q  <= pause_d;
      finish_q <= finish_d;
      ctl_q    <= 1'b0;
    end
  end

  assign write_en    = (state_q == WRITE) & sample_valid;
  assign o_sram_we   = ~write_en;
  assign o_sram_dq   = write_en ? sample : '0;
  assign o_sram_addr = addr_q;
  assign o_sram_ce   = ctl_q;
  assign o_sram_lb   = ctl_q;
  assign o_sram_ub   = ctl_q;
  assign o_sram_oe   = 1'b1;
  assign o_end_addr  = end_q;
  assign o_finish    = finish_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_record_ctrl.sv
// Self-checking bench for record_ctrl: I2S frames are driven cycle by cycle and
// SRAM writes, finish pulses and end addresses are compared with a recorder model.
module tb_record_ctrl;
  import record_pkg::*;

  localparam int M_IDLE   = 0;
  localparam int M_REC    = 1;
  localparam int M_PAUSED = 2;

  logic                clk = 1'b0;
  logic                rst, start, pause, stop, lrck, dat;
  logic [ADDR_W-1:0]   sram_addr, end_addr;
  logic [SAMPLE_W-1:0] sram_dq;
  logic                we, ce, oe, lb, ub, finish;
  state_e              dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [ADDR_W+SAMPLE_W-1:0] exp_q[$];

  int                m_mode = M_IDLE;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [ADDR_W-1:0] m_end  = '0;
  int                m_fin  = 0;

  int wr_cnt = 0, fin_cnt = 0, cyc = 0, wr_cyc = 0, fall_cyc = 0;

  record_ctrl dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_pause     (pause),
    .i_stop      (stop),
    .i_ADCLRCK   (lrck),
    .i_ADCDAT    (dat),
    .o_sram_addr (sram_addr),
    .o_sram_dq   (sram_dq),
    .o_sram_we   (we),
    .o_sram_ce   (ce),
    .o_sram_oe   (oe),
    .o_sram_lb   (lb),
    .o_sram_ub   (ub),
    .o_end_addr  (end_addr),
    .o_finish    (finish),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // scoreboard: every SRAM write cycle must match the oldest expected word
  always @(negedge clk) begin
    logic [ADDR_W+SAMPLE_W-1:0] e;
    if (we === 1'b0) begin
      wr_cnt++;
      wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("write_expected", 40'(exp_q.size()), 40'd1);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 40'(sram_addr), 40'(e[ADDR_W+SAMPLE_W-1:SAMPLE_W]));
        check("wr_dq", 40'(sram_dq), 40'(e[SAMPLE_W-1:0]));
      end
    end
    if (finish === 1'b1) fin_cnt++;
  end

  // reference model
  task automatic finish_model(input logic [ADDR_W-1:0] e);
    m_mode = M_IDLE;
    m_fin++;
    m_end = e;
  endtask

  task automatic model_frame(input logic [15:0] l, input int stop_at, input int pause_at,
                             input int rst_at);
    if (m_mode == M_IDLE) return;
    if (m_mode == M_PAUSED) begin
      if (stop_at >= 0) finish_model(m_addr);
      return;
    end
    if (stop_at >= 0 && stop_at <= 16) begin
      finish_model(m_addr);
      return;
    end
    exp_q.push_back({m_addr, l});
    if (rst_at == 17) begin
      m_mode = M_IDLE;
      m_addr = '0;
      m_end  = '0;
      return;
    end
    if (m_addr == MAX_ADDR) begin
      finish_model(MAX_ADDR);
      return;
    end
    m_addr++;
    if (stop_at >= 17) finish_model(m_addr);
    else if (pause_at >= 0 && pause_at <= 17) m_mode = M_PAUSED;
  endtask

  // driver tasks
  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int stop_at,
                            input int pause_at, input int rst_at);
    logic [15:0] w;
    int j;
    model_frame(l, stop_at, pause_at, rst_at);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rst_at >= 0 && i == rst_at + 1) begin
        check("rst_we", 40'(we), 40'd1);
        check("rst_dq", 40'(sram_dq), 40'd0);
        check("rst_addr", 40'(sram_addr), 40'd0);
        check("rst_end", 40'(end_addr), 40'd0);
        check("rst_finish", 40'(finish), 40'd0);
        check("rst_ctl", 40'({ce, lb, ub, oe}), 40'hF);
        check("rst_state", 40'(dbg_state), 40'(IDLE));
      end
      j     = i % 20;
      w     = (i >= 20) ? r : l;
      lrck  = (i >= 20);
      dat   = (j >= 1 && j <= 16) ? w[16 - j] : 1'b0;
      stop  = (i == stop_at);
      pause = (i == pause_at);
      rst   = (i == rst_at);
      if (i == 0) fall_cyc = cyc + 1;
    end
    @(negedge clk);
    stop  = 1'b0;
    pause = 1'b0;
    rst   = 1'b0;
    dat   = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_start();
    if (m_mode == M_IDLE) begin
      m_mode = M_REC;
      m_addr = '0;
    end else if (m_mode == M_PAUSED) begin
      m_mode = M_REC;
    end
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_stop();
    if (m_mode != M_IDLE) finish_model(m_addr);
    @(negedge clk) stop = 1'b1;
    @(negedge clk) stop = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_status(input string tag);
    state_e exp_s;
    exp_s = (m_mode == M_IDLE) ? IDLE : (m_mode == M_PAUSED) ? PAUSED : WAIT_L;
    check({tag, "_finishes"}, 40'(fin_cnt), 40'(m_fin));
    check({tag, "_pending"}, 40'(exp_q.size()), 40'd0);
    check({tag, "_state"}, 40'(dbg_state), 40'(exp_s));
    check({tag, "_addr"}, 40'(sram_addr), 40'(m_addr));
    if (m_mode == M_IDLE) check({tag, "_end_addr"}, 40'(end_addr), 40'(m_end));
  endtask

  function automatic logic [15:0] rnd16();
    return 16'($urandom_range(0, 65535));
  endfunction

  initial begin
    int wr0, s_at, p_at;
    rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0; lrck = 1'b1; dat = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_we", 40'(we), 40'd1);
    check("reset_dq", 40'(sram_dq), 40'd0);
    check("reset_addr", 40'(sram_addr), 40'd0);
    check("reset_end", 40'(end_addr), 40'd0);
    check("reset_finish", 40'(finish), 40'd0);
    check("reset_ctl", 40'({ce, lb, ub, oe}), 40'hF);
    check("reset_state", 40'(dbg_state), 40'(IDLE));
    rst = 1'b0;
    @(negedge clk);
    check("run_ctl", 40'({ce, lb, ub, oe}), 40'h1);

    // stop while idle is ignored
    do_stop();
    check_status("idle_stop");

    // single word, exact write timing
    do_start();
    wr0 = wr_cnt;
    send_frame(16'hAC54, rnd16(), -1, -1, -1);
    check("single_write_count", 40'(wr_cnt - wr0), 40'd1);
    check("single_write_latency", 40'(wr_cyc - fall_cyc), 40'd16);
    check_status("single");
    do_stop();
    check_status("single_stop");

    // three frames, right channel discarded
    do_start();
    send_frame(16'h1234, 16'h5555, -1, -1, -1);
    send_frame(16'h8001, 16'h5555, -1, -1, -1);
    send_frame(16'hFFFF, 16'h5555, -1, -1, -1);
    check_status("three");
    do_stop();
    check_status("three_stop");

    // pause during second sample, resume keeps address
    do_start();
    send_frame(rnd16(), rnd16(), -1, -1, -1);
    send_frame(rnd16(), rnd16(), -1, 8, -1);
    wr0 = wr_cnt;
    send_frame(rnd16(), rnd16(), -1, -1, -1);
    check("paused_no_write", 40'(wr_cnt - wr0), 40'd0);
    check_status("paused");
    do_start();
    send_frame(rnd16(), rnd16(), -1, -1, -1);
    send_frame(rnd16(), rnd16(), -1, -1, -1);
    send_frame(rnd16(), rnd16(), -1, -1, -1);
    check_status("resumed");

    // stop mid-shift after five writes
    wr0 = wr_cnt;
    send_frame(rnd16(), rnd16(), 8, -1, -1);
    check("stop_no_write", 40'(wr_cnt - wr0), 40'd0);
    check_status("stop_shift");
    send_frame(rnd16(), rnd16(), -1, -1, -1);
    check_status("end_hold");

    // top of memory: two writes then auto-finish without wrap
    do_start();
    @(negedge clk) force dut.addr_q = 20'hFFFFE;
    @(negedge clk) release dut.addr_q;
    m_addr = 20'hFFFFE;
    send_frame(rnd16(), rnd16(), -1, -1, -1);
    send_frame(rnd16(), rnd16(), -1, -1, -1);
    check_status("full");
    send_frame(rnd16(), rnd16(), -1, -1, -1);
    check_status("full_idle");

    // reset during the write cycle
    do_start();
    send_frame(rnd16(), rnd16(), -1, -1, -1);
    send_frame(rnd16(), rnd16(), -1, -1, 17);
    check_status("rst_write");

    // stop and pause together: stop wins
    do_start();
    send_frame(rnd16(), rnd16(), 8, 8, -1);
    check_status("stop_pause");

    // randomized session
    for (int k = 0; k < 12; k++) begin
      if (m_mode != M_REC) do_start();
      s_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 39)) : -1;
      p_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 17)) : -1;
      send_frame(rnd16(), rnd16(), s_at, p_at, -1);
      check_status("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
